// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types, opcodes and frame-size helpers for the hardware stacking sequencer.
package ibex_pkg;

  typedef enum logic {HWS_SAVE = 1'b0, HWS_RESTORE = 1'b1} hw_stacking_mode_t;

  typedef enum logic [2:0] {S_IDLE, S_ALLOC, S_GPR, S_CSR, S_DEALLOC, S_DONE} hws_state_t;

  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } load_sp_t;

  typedef struct packed {
    logic [6:0] imm_hi;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] imm_lo;
    logic [6:0] opcode;
  } store_sp_t;

  localparam logic [6:0]  OPCODE_LOAD   = 7'h03;
  localparam logic [6:0]  OPCODE_STORE  = 7'h23;
  localparam logic [6:0]  OPCODE_OP_IMM = 7'h13;
  localparam logic [31:0] HWS_NOP       = 32'h0000_0013;

  function automatic int unsigned hws_popcount(logic [31:0] m);
    int unsigned c = 0;
    for (int i = 0; i < 32; i++) c += 32'(m[i]);
    return c;
  endfunction

  function automatic int unsigned hws_frame_bytes(logic [31:0] m, int unsigned ncsr, int unsigned align);
    int unsigned b = 4 * (hws_popcount(m) + ncsr);
    return ((b + align - 1) / align) * align;
  endfunction

  // k-th set bit of the mask, ascending; mask is a parameter so this folds to a constant table
  function automatic logic [4:0] hws_gpr_idx(logic [31:0] m, int unsigned k);
    int unsigned c = 0;
    logic [4:0] idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) begin
        if (c == k) idx = 5'(i);
        c++;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rt_ibex_hws_encoder.sv
// rt_ibex_hws_encoder: builds the SP adjust / SP-relative sw or lw word for one stacking slot.
module rt_ibex_hws_encoder
  import ibex_pkg::*;
(
  input  logic        restore,
  input  logic        adj,
  input  logic [4:0]  rgs,
  input  logic [11:0] offset,
  input  logic [11:0] frame,
  output logic [31:0] instr
);
  load_sp_t  ld, ad;
  store_sp_t st;
  assign ld = '{imm: offset, rs1: 5'd2, funct3: 3'b010, rd: rgs, opcode: OPCODE_LOAD};
  assign ad = '{imm: restore ? frame : -frame, rs1: 5'd2, funct3: 3'b000, rd: 5'd2, opcode: OPCODE_OP_IMM};
  assign st = '{imm_hi: offset[11:5], rs2: rgs, rs1: 5'd2, funct3: 3'b010, imm_lo: offset[4:0], opcode: OPCODE_STORE};
  assign instr = adj ? 32'(ad) : restore ? 32'(ld) : 32'(st);
endmodule

// File: rtl/rt_ibex_hws_seq.sv
// rt_ibex_hws_seq: hardware context save/restore sequencer injecting SP adjust and sw/lw into ID.
// Optional RT_IBEX_HWS_LATE_ABORT_EN enables late abort of RESTORE for tail-chaining.
module rt_ibex_hws_seq
  import ibex_pkg::*;
#(
  parameter logic [31:0] REG_MASK    = 32'h0000_BC22,
  parameter int unsigned NUM_CSR     = 2,
  parameter int unsigned STACK_ALIGN = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  hw_stacking_mode_t mode_i,
  input  logic              ack_i,
  input  logic              abort_i,
  input  logic              id_in_ready_i,
  input  logic              if_id_pipe_reg_we_i,
  input  logic [31:0]       if_inst_bypass_i,
  output logic              instr_valid_o,
  output logic [31:0]       instr_rdata_o,
  output logic              instr_is_compressed_o,
  output logic              id_mux_ctrl_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o,
  output logic [1:0]        lsu_data_select_o,
  output logic              csr_fast_lsu_o,
  output logic              csr_select_o,
  output logic              mcause_pending_o
);
  localparam int unsigned NPOP  = hws_popcount(REG_MASK);
  localparam int unsigned N     = NPOP + NUM_CSR;
  localparam int unsigned FRAME = hws_frame_bytes(REG_MASK, NUM_CSR, STACK_ALIGN);
  localparam logic [4:0]  LAST_PTR  = 5'(NPOP - 1);
  localparam logic [5:0]  LAST_SLOT = 6'(N - 1);

  if (REG_MASK[0] || REG_MASK[2]) begin : g_chk_mask
    $error("REG_MASK must not include x0 or sp");
  end
  if (NUM_CSR > 2) begin : g_chk_csr
    $error("NUM_CSR must be 0..2");
  end
  if (STACK_ALIGN < 4 || (STACK_ALIGN & (STACK_ALIGN - 1)) != 0) begin : g_chk_align
    $error("STACK_ALIGN must be a power of two >= 4");
  end
  if (FRAME > 2044) begin : g_chk_frame
    $error("frame exceeds addi immediate range");
  end

  hws_state_t        state_q, nxt;
  hw_stacking_mode_t mode_q, nxt_mode;
  logic [5:0]        slot_q, nxt_slot;
  logic [4:0]        ptr_q, nxt_ptr;
  logic              accept, restore, issue, csr_sel;
  logic [4:0]        rgs;
  logic [31:0]       enc;
  hws_state_t        after_csr, after_gpr, after_alloc, rst_first;

  assign accept      = instr_valid_o && id_in_ready_i;
  assign restore     = nxt_mode == HWS_RESTORE;
  assign after_csr   = mode_q == HWS_RESTORE ? S_DEALLOC : S_DONE;
  assign after_gpr   = NUM_CSR > 0 ? S_CSR : after_csr;
  assign after_alloc = NPOP > 0 ? S_GPR : NUM_CSR > 0 ? S_CSR : S_DONE;
  assign rst_first   = NPOP > 0 ? S_GPR : NUM_CSR > 0 ? S_CSR : S_DEALLOC;

`ifdef RT_IBEX_HWS_LATE_ABORT_EN
  logic abort_hit;
  assign abort_hit = abort_i && mode_q == HWS_RESTORE && (state_q inside {S_GPR, S_CSR, S_DEALLOC});
`endif

  always_comb begin
    nxt      = state_q;
    nxt_mode = mode_q;
    nxt_slot = slot_q;
    nxt_ptr  = ptr_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        nxt_mode = mode_i;
        nxt_slot = 6'd0;
        nxt_ptr  = 5'd0;
        nxt      = mode_i == HWS_RESTORE ? rst_first : S_ALLOC;
      end
      S_ALLOC: nxt = accept ? after_alloc : S_ALLOC;
      S_GPR: if (accept) begin
        nxt_slot = slot_q + 6'd1;
        nxt_ptr  = ptr_q + 5'd1;
        nxt      = ptr_q == LAST_PTR ? after_gpr : S_GPR;
      end
      S_CSR: if (accept) begin
        nxt_slot = slot_q + 6'd1;
        nxt      = slot_q == LAST_SLOT ? after_csr : S_CSR;
      end
      S_DEALLOC: nxt = accept ? S_DONE : S_DEALLOC;
      S_DONE: nxt = ack_i ? S_IDLE : S_DONE;
      default: nxt = S_IDLE;
    endcase
`ifdef RT_IBEX_HWS_LATE_ABORT_EN
    if (abort_hit) nxt = S_DONE;
`endif
  end

  // Outputs are registered from next-state values so nothing combinational reaches the controller
  assign issue   = nxt inside {S_ALLOC, S_GPR, S_CSR, S_DEALLOC};
  assign csr_sel = nxt == S_CSR && nxt_slot != 6'(NPOP);
  assign rgs     = nxt == S_GPR ? hws_gpr_idx(REG_MASK, 32'(nxt_ptr)) : 5'd0;

  rt_ibex_hws_encoder u_enc (
    .restore(restore),
    .adj    (nxt == S_ALLOC || nxt == S_DEALLOC),
    .rgs    (rgs),
    .offset ({4'b0, nxt_slot, 2'b00}),
    .frame  (12'(FRAME)),
    .instr  (enc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= S_IDLE;
      mode_q            <= HWS_SAVE;
      slot_q            <= 6'd0;
      ptr_q             <= 5'd0;
      instr_valid_o     <= 1'b0;
      instr_rdata_o     <= HWS_NOP;
      id_mux_ctrl_o     <= 1'b0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      lsu_data_select_o <= 2'b00;
      csr_fast_lsu_o    <= 1'b0;
      csr_select_o      <= 1'b0;
      mcause_pending_o  <= 1'b0;
    end else begin
      state_q           <= nxt;
      mode_q            <= nxt_mode;
      slot_q            <= nxt_slot;
      ptr_q             <= nxt_ptr;
      instr_valid_o     <= issue;
      instr_rdata_o     <= issue ? enc : if_id_pipe_reg_we_i ? if_inst_bypass_i : instr_rdata_o;
      id_mux_ctrl_o     <= issue;
      busy_o            <= nxt != S_IDLE;
      done_o            <= nxt == S_DONE;
      lsu_data_select_o <= nxt != S_CSR ? 2'b00 : csr_sel ? 2'b10 : 2'b01;
      csr_fast_lsu_o    <= nxt == S_CSR;
      csr_select_o      <= csr_sel;
      mcause_pending_o  <= csr_sel;
    end
  end

  assign instr_is_compressed_o = 1'b0;

`ifdef RT_IBEX_HWS_LATE_ABORT_EN
  always_ff @(posedge clk_i) begin
    aborted_o <= rst_i ? 1'b0 : nxt == S_DONE && (abort_hit || (state_q == S_DONE && aborted_o));
  end
`else
  logic unused_abort;
  assign unused_abort = abort_i;
  assign aborted_o    = 1'b0;
`endif

endmodule
